// File: rtl/multdiv_unit.sv
// Iterative signed mul/div beside X: 33-cycle accept-to-mul_rdy (div-by-zero: 1), stall holds a new mul/div in D/X while occupied.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module multdiv_unit #(
  parameter int         WIDTH  = 32,
  parameter logic [4:0] OP_MUL = 5'b00110,
  parameter logic [4:0] OP_DIV = 5'b00111
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      dx_ir,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic [31:0]      mul_ir,
  output logic             mul_rdy,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             busy,
  output logic             stall
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_q;
  logic [5:0]           cnt_q;
  logic [31:0]          mul_ir_q;
  logic                 is_div_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     result_q;
  logic                 exc_q;
  logic                 rdy_q;

  logic                 dx_muldiv;
  logic                 dx_is_div;
  logic                 accept;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [2*WIDTH-1:0]   mul_acc_d;
  logic [2*WIDTH-1:0]   mcand_d;
  logic [WIDTH-1:0]     mplier_d;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   div_acc_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     fin_result;
  logic                 fin_exc;
  logic                 last_iter;

  always_comb begin
    dx_muldiv = (dx_ir[31:27] == 5'd0) && ((dx_ir[6:2] == OP_MUL) || (dx_ir[6:2] == OP_DIV));
    dx_is_div = (dx_ir[6:2] == OP_DIV);
    accept    = dx_muldiv && !flush && (state_q == S_IDLE);
    a_abs     = operand_a[WIDTH-1] ? -operand_a : operand_a;
    b_abs     = operand_b[WIDTH-1] ? -operand_b : operand_b;

    // Shift-add: multiplicand walks left, multiplier walks right.
    mul_acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d   = {mcand_q[2*WIDTH-2:0], 1'b0};
    mplier_d  = {1'b0, mplier_q[WIDTH-1:1]};

    // Restoring division on {remainder, dividend/quotient}; divisor sits in mcand_q low word.
    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    diff      = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
    div_acc_d = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    acc_d      = is_div_q ? div_acc_d : mul_acc_d;
    prod_s     = neg_q ? -acc_d : acc_d;
    quo_s      = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    fin_result = is_div_q ? quo_s : prod_s[WIDTH-1:0];
    // A positive quotient with bit 31 set only arises from MIN / -1.
    fin_exc    = is_div_q ? (!neg_q && acc_d[WIDTH-1])
                          : (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});

`ifdef MULDIV_EARLY_OUT_EN
    last_iter = (cnt_q == 6'(WIDTH-1)) || (!is_div_q && (mplier_d == '0));
`else
    last_iter = (cnt_q == 6'(WIDTH-1));
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mul_ir_q <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b0;
          if (accept) begin
            mul_ir_q <= dx_ir;
            is_div_q <= dx_is_div;
            neg_q    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            if (dx_is_div) begin
              acc_q    <= {{WIDTH{1'b0}}, a_abs};
              mcand_q  <= {{WIDTH{1'b0}}, b_abs};
              mplier_q <= '0;
            end else begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a_abs};
              mplier_q <= b_abs;
            end
            if (dx_is_div && (operand_b == '0)) begin
              state_q <= S_DONE;
              rdy_q   <= 1'b1;
              exc_q   <= 1'b1;
            end else begin
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= is_div_q ? mcand_q : mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 6'd1;
          if (last_iter) begin
            state_q  <= S_DONE;
            rdy_q    <= 1'b1;
            result_q <= fin_result;
            exc_q    <= fin_exc;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          rdy_q    <= 1'b0;
          mul_ir_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mul_ir    = mul_ir_q;
  assign mul_rdy   = rdy_q;
  assign result    = result_q;
  assign exception = exc_q;
  assign busy      = (state_q != S_IDLE);
  assign stall     = dx_muldiv && (state_q != S_IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: expected results queued at issue, checked when mul_rdy pulses.
module tb_multdiv_unit;

  localparam logic [31:0] IR_MUL  = 32'h0042_1818;
  localparam logic [31:0] IR_MUL2 = 32'h0085_2018;
  localparam logic [31:0] IR_DIV  = 32'h0063_201C;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dx_ir = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic [31:0] mul_ir;
  logic        mul_rdy;
  logic [31:0] result;
  logic        exception;
  logic        busy;
  logic        stall;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] res;
    logic        exc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  multdiv_unit dut (
    .clock(clock), .reset(reset), .dx_ir(dx_ir), .operand_a(operand_a),
    .operand_b(operand_b), .flush(flush), .mul_ir(mul_ir), .mul_rdy(mul_rdy),
    .result(result), .exception(exception), .busy(busy), .stall(stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int mul_lat(input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] m;
    int n;
    m = b[31] ? -b : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n + 1;
`else
    return (b == b) ? 33 : 33;
`endif
  endfunction

  // Reference arithmetic from the language's signed operators.
  task automatic model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc);
    longint p;
    if (!is_div) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      res = '0; exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000; exc = 1'b1;
    end else begin
      res = $signed(a) / $signed(b); exc = 1'b0;
    end
  endtask

  // Drives one instruction for one edge and queues its expectation.
  task automatic issue(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic exc, input int lat);
    exp_t e;
    e.ir = ir; e.res = res; e.exc = exc; e.lat = lat;
    sb.push_back(e);
    dx_ir = ir; operand_a = a; operand_b = b;
    @(posedge clock);
    #1;
    dx_ir = '0; operand_a = '0; operand_b = '0;
  endtask

  task automatic wait_result(input int first_cyc);
    exp_t e;
    int lat;
    lat = 0;
    for (int k = first_cyc; k < first_cyc + 100; k++) begin
      @(negedge clock);
      if (mul_rdy) begin
        lat = k;
        break;
      end
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("result", result, e.res);
    check("exception", {31'd0, exception}, {31'd0, e.exc});
    check("mul_ir_done", mul_ir, e.ir);
    @(negedge clock);
    check("rdy_pulse", {31'd0, mul_rdy}, 32'd0);
    check("mul_ir_clear", mul_ir, 32'd0);
  endtask

  task automatic run_model(input logic is_div, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        x;
    model(is_div, a, b, r, x);
    issue(is_div ? IR_DIV : IR_MUL, a, b, r, x,
          (is_div && b == 0) ? 1 : (is_div ? 33 : mul_lat(b)));
    wait_result(1);
  endtask

  initial begin
    #1;
    check("rst_mul_ir", mul_ir, 32'd0);
    check("rst_outs", {27'd0, mul_rdy, exception, busy, stall, 1'b0}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    issue(IR_MUL, 32'd7, -32'sd6, 32'hFFFF_FFD6, 1'b0, mul_lat(-32'sd6));
    wait_result(1);
    issue(IR_DIV, -32'sd17, 32'd5, 32'hFFFF_FFFD, 1'b0, 33);
    wait_result(1);
    issue(IR_DIV, 32'd100, 32'd0, 32'd0, 1'b1, 1);
    wait_result(1);
    issue(IR_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
    wait_result(1);
    issue(IR_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, mul_lat(32'h0001_0000));
    wait_result(1);
    issue(IR_MUL, 32'h0000_8000, 32'h0000_8000, 32'h4000_0000, 1'b0, mul_lat(32'h0000_8000));
    wait_result(1);

    // Second mul held in D/X while the first is in flight.
    issue(IR_MUL, 32'd9, 32'd11, 32'd99, 1'b0, mul_lat(32'd11));
    sb.push_back('{ir: IR_MUL2, res: 32'hFFFF_FF38, exc: 1'b0, lat: mul_lat(32'd8)});
    dx_ir = IR_MUL2; operand_a = -32'sd25; operand_b = 32'd8;
    @(negedge clock);
    check("stall_busy", {31'd0, stall}, 32'd1);
    check("busy_on", {31'd0, busy}, 32'd1);
    wait_result(2);
    check("stall_idle", {31'd0, stall}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
    dx_ir = '0; operand_a = '0; operand_b = '0;
    check("second_accepted", {31'd0, busy}, 32'd1);
    wait_result(1);

    // Flush in the acceptance cycle.
    dx_ir = IR_MUL; operand_a = 32'd3; operand_b = 32'd4; flush = 1'b1;
    @(posedge clock);
    #1;
    dx_ir = '0; flush = 1'b0;
    @(negedge clock);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_mul_ir", mul_ir, 32'd0);

    // Reset in the middle of an iteration run.
    issue(IR_MUL, 32'd1234, 32'd5678, 32'd7006652, 1'b0, mul_lat(32'd5678));
    repeat (10) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("arst_mul_ir", mul_ir, 32'd0);
    check("arst_outs", {27'd0, mul_rdy, exception, busy, stall, 1'b0}, 32'd0);
    check("arst_result", result, 32'd0);
    void'(sb.pop_front());
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    issue(IR_MUL, -32'sd300, -32'sd41, 32'd12300, 1'b0, mul_lat(-32'sd41));
    wait_result(1);

    for (int i = 0; i < 6; i++) begin
      run_model(i[0], $urandom, (i == 4) ? 32'd1 : $urandom_range(1, 32'hFFFF) ^ (i[1] ? 32'hFFFF_0000 : 32'd0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed multiply/divide unit beside the X stage of the 5-stage pipeline.
- Captures an R-type mul/div instruction from the D/X latch together with its operands, then iterates.
- Presents the instruction (mul_ir), result and a one-cycle mul_rdy to the control decoder and W-stage write-back mux.
- Drives the stall that holds a second mul/div in D/X while the unit is occupied.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- OP_MUL, 5'b00110, ALU-op field value (ir[6:2]) for mul.
- OP_DIV, 5'b00111, ALU-op field value (ir[6:2]) for div.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- dx_ir  input  32  instruction in D/X latch.
- operand_a  input  32  forwarded rs value (dividend / multiplicand).
- operand_b  input  32  forwarded rt value (divisor / multiplier).
- flush  input  1  D/X instruction is being squashed this cycle.
- mul_ir  output  32  captured mul/div instruction; 32'b0 when idle.
- mul_rdy  output  1  result valid this cycle (one-cycle pulse).
- result  output  32  quotient or product low word.
- exception  output  1  overflow or divide-by-zero, valid with mul_rdy.
- busy  output  1  unit not IDLE.
- stall  output  1  mul/div in D/X cannot be accepted.

Behaviour:
- Reset: all outputs 0; state IDLE; counter, accumulators and mul_ir cleared. Reset mid-operation abandons the operation; nothing is written back.
- Decode: dx_muldiv = (dx_ir[31:27]==0) & (dx_ir[6:2]==OP_MUL | OP_DIV).
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY on rising edge when dx_muldiv & ~flush:
  - Latch dx_ir into mul_ir.
  - Latch |operand_a|, |operand_b| and result sign (a[31]^b[31]).
  - Clear the 6-bit counter.
- Div with operand_b==0: IDLE -> DONE directly (result 0, exception 1).
- BUSY, mul: shift-add, one multiplier bit per cycle; 64-bit unsigned product.
- BUSY, div: restoring division, one quotient bit per cycle.
- Counter increments each BUSY cycle; BUSY -> DONE after WIDTH iterations (counter==WIDTH-1).
- Latency: mul_rdy asserted in the 33rd cycle after the accepting edge (DONE cycle), normal case.
- DONE:
  - mul_rdy=1.
  - result = sign-corrected product low word or quotient (truncation toward zero).
  - mul_ir still holds the instruction.
  - Next edge -> IDLE; mul_ir returns to 0, mul_rdy 0.
- exception:
  - mul: signed product does not fit in 32 bits; result is still the low word.
  - div: divisor zero, or 0x80000000 / -1 (result 0x80000000).
- A new mul/div is accepted only from IDLE; no acceptance in the DONE cycle.
- stall = dx_muldiv & (state != IDLE).
- flush has no effect on an operation already accepted.
- Flush in the acceptance cycle blocks acceptance.
- result and exception hold their DONE values until the next acceptance; consumers qualify them with mul_rdy.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: a multiply moves BUSY -> DONE on the edge where the remaining unshifted multiplier bits are all zero. A multiplier of 0 or 1 finishes after 1 BUSY cycle. Division is unchanged.
- Undefined: every multiply takes the full WIDTH iterations.

Test Plan:
- mul 7 * -6, accepted at edge 0 -> mul_rdy=1 only in cycle 33; result 0xFFFFFFD6; exception 0; mul_ir equals the issued word.
- div -17 / 5 -> result 0xFFFFFFFD, exception 0; mul_rdy a single-cycle pulse; mul_ir 0 the cycle after.
- div 100 / 0 -> mul_rdy in cycle 1 after acceptance; result 0; exception 1. Separately, div 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1.
- mul 0x00010000 * 0x00010000 -> result 0x00000000, exception 1. Separately, mul 0x00008000 * 0x00008000 -> 0x40000000, exception 0.
- Second mul in D/X while BUSY -> stall=1 through DONE, accepted on the first IDLE edge. A mul with flush=1 in IDLE -> not accepted, busy stays 0.
- Reset pulsed at iteration 10 -> all outputs 0 asynchronously, state IDLE; the next mul completes with a correct result.
